// File: rtl/conv3x3_mac_pe.sv
// 3x3 window MAC processing element: accumulates over channels, adds bias, round-shifts and saturates.
// Optional macro CONV_PE_RELU_EN clamps negative results to zero before saturation.
module conv3x3_mac_pe #(
    parameter int DATA_W = 8,
    parameter int BIAS_W = 8,
    parameter int OUT_W  = 8,
    parameter int ACC_W  = 32,
    parameter int MAX_CH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [9*DATA_W-1:0]   ifm_win,
    input  logic [9*DATA_W-1:0]   wgt_win,
    input  logic [BIAS_W-1:0]     bias_in,
    input  logic [4:0]            shift_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      ofm_out,
    output logic                  ch_ovf
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(MAX_CH + 1);

    typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;

    state_t state_q, state_d;

    logic signed [DATA_W-1:0] ifm_e [9];
    logic signed [DATA_W-1:0] wgt_e [9];
    logic signed [PROD_W-1:0] prod_d [9];
    logic signed [PROD_W-1:0] prod_p1_q [9];
    logic                     vld_p1_q, last_p1_q;
    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  sum_p2_q;
    logic                     vld_p2_q, last_p2_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  res_p3_q;
    logic                     vld_p3_q;
    logic signed [BIAS_W-1:0] bias_q;
    logic [4:0]               shift_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [OUT_W-1:0]  ofm_q, ofm_d;
    logic                     out_valid_q;
    logic                     ch_ovf_q;

    logic accept, cnt_at_max, last_beat, ovf_beat;

    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] r,
                                                          input logic [4:0] sh);
        logic signed [ACC_W:0] x;
        x = (ACC_W+1)'(r);
        if (sh != 5'd0) begin
            x = x + ((ACC_W+1)'(1) <<< (sh - 5'd1));
            x = x >>> sh;
        end
        return x;
    endfunction

    function automatic logic signed [ACC_W:0] relu(input logic signed [ACC_W:0] x);
        return (x < 0) ? '0 : x;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] x);
        logic signed [ACC_W:0] hi, lo;
        hi = (ACC_W+1)'((1 <<< (OUT_W-1)) - 1);
        lo = -hi - 1;
        if (x > hi)      return OUT_W'(hi);
        else if (x < lo) return OUT_W'(lo);
        else             return OUT_W'(x);
    endfunction

    assign in_ready   = (state_q == ACC);
    assign accept     = in_valid && in_ready;
    assign cnt_at_max = (cnt_q == CNT_W'(MAX_CH - 1));
    assign last_beat  = accept && (in_last || cnt_at_max);
    assign ovf_beat   = accept && !in_last && cnt_at_max;

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            ifm_e[k]  = ifm_win[k*DATA_W +: DATA_W];
            wgt_e[k]  = wgt_win[k*DATA_W +: DATA_W];
            prod_d[k] = PROD_W'(ifm_e[k]) * PROD_W'(wgt_e[k]);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < 9; k++) begin
            sum_d = sum_d + ACC_W'(prod_p1_q[k]);
        end
    end

`ifdef CONV_PE_RELU_EN
    assign ofm_d = saturate(relu(round_shift(res_p3_q, shift_q)));
`else
    assign ofm_d = saturate(round_shift(res_p3_q, shift_q));
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (last_beat) state_d = DRAIN;
            DRAIN:   if (vld_p3_q) state_d = OUT;
            OUT:     if (out_valid_q && out_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            vld_p1_q    <= 1'b0;
            last_p1_q   <= 1'b0;
            vld_p2_q    <= 1'b0;
            last_p2_q   <= 1'b0;
            vld_p3_q    <= 1'b0;
            sum_p2_q    <= '0;
            acc_q       <= '0;
            res_p3_q    <= '0;
            bias_q      <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            ofm_q       <= '0;
            out_valid_q <= 1'b0;
            ch_ovf_q    <= 1'b0;
            for (int k = 0; k < 9; k++) prod_p1_q[k] <= '0;
        end else begin
            state_q <= state_d;
            // S1: products of the accepted beat
            vld_p1_q  <= accept;
            last_p1_q <= last_beat;
            if (accept) begin
                for (int k = 0; k < 9; k++) prod_p1_q[k] <= prod_d[k];
            end
            if (last_beat) begin
                bias_q  <= bias_in;
                shift_q <= shift_in;
            end
            if (ovf_beat) ch_ovf_q <= 1'b1;
            // S2: adder tree
            vld_p2_q  <= vld_p1_q;
            last_p2_q <= last_p1_q;
            if (vld_p1_q) sum_p2_q <= sum_d;
            // S3: accumulate, or fold in bias and close the pixel
            vld_p3_q <= vld_p2_q && last_p2_q;
            if (vld_p2_q && last_p2_q) begin
                res_p3_q <= acc_q + sum_p2_q + ACC_W'(bias_q);
                acc_q    <= '0;
                cnt_q    <= '0;
            end else begin
                if (vld_p2_q) acc_q <= acc_q + sum_p2_q;
                if (accept)   cnt_q <= cnt_q + 1'b1;
            end
            // Output register: round, saturate, hold until handshake
            if (vld_p3_q) begin
                ofm_q       <= ofm_d;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign ofm_out   = ofm_q;
    assign ch_ovf    = ch_ovf_q;

endmodule

// File: tb/tb_conv3x3_mac_pe.sv
// Directed bench for conv3x3_mac_pe built with MAX_CH=4; expected pixels are hand-computed.
module tb_conv3x3_mac_pe;

    localparam int DATA_W = 8;
    localparam int BIAS_W = 8;
    localparam int OUT_W  = 8;
    localparam int ACC_W  = 32;
    localparam int MAX_CH = 4;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [9*DATA_W-1:0] ifm_win;
    logic [9*DATA_W-1:0] wgt_win;
    logic [BIAS_W-1:0]   bias_in;
    logic [4:0]          shift_in;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    ofm_out;
    logic                ch_ovf;

    int vectors = 0;
    int errs    = 0;

    conv3x3_mac_pe #(
        .DATA_W(DATA_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .MAX_CH(MAX_CH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .ifm_win(ifm_win), .wgt_win(wgt_win), .bias_in(bias_in), .shift_in(shift_in),
        .out_valid(out_valid), .out_ready(out_ready), .ofm_out(ofm_out), .ch_ovf(ch_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_beat(input logic signed [7:0] a, input logic signed [7:0] b,
                              input logic last, input logic signed [7:0] bias,
                              input logic [4:0] sh, output bit ok);
        ifm_win  = {9{a}};
        wgt_win  = {9{b}};
        in_last  = last;
        bias_in  = bias;
        shift_in = sh;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_single(input logic signed [7:0] a, input logic signed [7:0] b,
                              input logic signed [7:0] bias, input logic [4:0] sh,
                              output logic signed [7:0] v, output bit ok);
        bit ok_in;
        drive_beat(a, b, 1'b1, bias, sh, ok_in);
        wait_out(ok);
        ok = ok && ok_in;
        v = ofm_out;
        if (ok) take_out();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        ifm_win = '0; wgt_win = '0; bias_in = '0; shift_in = '0;
        #12;
        vectors++;
        if ({out_valid, ofm_out, ch_ovf} !== 10'b0) begin
            errs++;
            $display("FAIL reset_outputs: got valid=%b ofm=%0d ovf=%b, need 0/0/0", out_valid, ofm_out, ch_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_single_latency();
        bit ok;
        drive_beat(8'sd1, 8'sd2, 1'b1, 8'sd3, 5'd0, ok);
        vectors++;
        if (!ok) begin
            errs++;
            $display("FAIL single_accept: beat not accepted within bound");
        end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== (i == 3) || in_ready !== 1'b0) begin
                errs++;
                $display("FAIL single_latency: edge +%0d got valid=%b ready=%b, need valid=%b ready=0",
                         i, out_valid, in_ready, (i == 3));
            end
        end
        vectors++;
        if ($signed(ofm_out) !== 8'sd21) begin
            errs++;
            $display("FAIL single_value: got %0d need 21", $signed(ofm_out));
        end
        take_out();
    endtask

    task automatic test_multi_round();
        bit ok1, ok2, ok3;
        drive_beat(8'sd10, 8'sd10, 1'b0, 8'sd0, 5'd0, ok1);
        vectors++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL multi_ready_mid: got %b need 1", in_ready);
        end
        drive_beat(8'sd10, 8'sd10, 1'b1, 8'sd0, 5'd4, ok2);
        wait_out(ok3);
        vectors++;
        if (!(ok1 && ok2 && ok3) || $signed(ofm_out) !== 8'sd113) begin
            errs++;
            $display("FAIL multi_round: got %0d (ok=%b%b%b) need 113", $signed(ofm_out), ok1, ok2, ok3);
        end
        if (ok3) take_out();
    endtask

    task automatic test_saturation();
        logic signed [7:0] v;
        bit ok;
        run_single(8'sd127, 8'sd127, 8'sd127, 5'd0, v, ok);
        vectors++;
        if (!ok || v !== 8'sd127) begin
            errs++;
            $display("FAIL sat_pos: got %0d (ok=%b) need 127", v, ok);
        end
        run_single(-8'sd128, 8'sd127, 8'sd127, 5'd0, v, ok);
        vectors++;
        if (!ok || v !== -8'sd128) begin
            errs++;
            $display("FAIL sat_neg: got %0d (ok=%b) need -128", v, ok);
        end
    endtask

    task automatic test_bias_sign();
        logic signed [7:0] v;
        bit ok;
        run_single(8'sd1, 8'sd2, -8'sd3, 5'd0, v, ok);
        vectors++;
        if (!ok || v !== 8'sd15) begin
            errs++;
            $display("FAIL bias_neg: got %0d (ok=%b) need 15", v, ok);
        end
    endtask

    task automatic test_relu();
        logic signed [7:0] v, exp_a, exp_b;
        bit ok;
`ifdef CONV_PE_RELU_EN
        exp_a = 8'sd0;
        exp_b = 8'sd0;
`else
        exp_a = -8'sd45;
        exp_b = -8'sd2;
`endif
        run_single(-8'sd1, 8'sd5, 8'sd0, 5'd0, v, ok);
        vectors++;
        if (!ok || v !== exp_a) begin
            errs++;
            $display("FAIL neg_result: got %0d (ok=%b) need %0d", v, ok, exp_a);
        end
        run_single(-8'sd1, 8'sd1, 8'sd0, 5'd2, v, ok);
        vectors++;
        if (!ok || v !== exp_b) begin
            errs++;
            $display("FAIL neg_round: got %0d (ok=%b) need %0d", v, ok, exp_b);
        end
    endtask

    task automatic test_backpressure();
        logic signed [7:0] v;
        bit ok_in, ok;
        drive_beat(8'sd3, 8'sd3, 1'b1, 8'sd0, 5'd0, ok_in);
        wait_out(ok);
        vectors++;
        if (!(ok_in && ok)) begin
            errs++;
            $display("FAIL bp_valid: got ok=%b%b need 11", ok_in, ok);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || $signed(ofm_out) !== 8'sd81 || in_ready !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold: cycle %0d got valid=%b ofm=%0d ready=%b, need 1/81/0",
                         i, out_valid, $signed(ofm_out), in_ready);
            end
        end
        take_out();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL bp_release: got valid=%b ready=%b need 0/1", out_valid, in_ready);
        end
        run_single(8'sd2, 8'sd2, 8'sd0, 5'd0, v, ok);
        vectors++;
        if (!ok || v !== 8'sd36) begin
            errs++;
            $display("FAIL bp_next_pixel: got %0d (ok=%b) need 36", v, ok);
        end
    endtask

    task automatic test_ch_overflow();
        bit ok, okb;
        vectors++;
        if (ch_ovf !== 1'b0) begin
            errs++;
            $display("FAIL ovf_before: got %b need 0", ch_ovf);
        end
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(8'sd1, 8'sd1, 1'b0, 8'sd100, 5'd3, okb);
            ok = ok && okb;
        end
        vectors++;
        if (!ok || in_ready !== 1'b1 || ch_ovf !== 1'b0) begin
            errs++;
            $display("FAIL ovf_mid: got ok=%b ready=%b ovf=%b need 1/1/0", ok, in_ready, ch_ovf);
        end
        drive_beat(8'sd1, 8'sd1, 1'b0, 8'sd5, 5'd0, okb);
        wait_out(ok);
        vectors++;
        if (!(ok && okb) || $signed(ofm_out) !== 8'sd41 || ch_ovf !== 1'b1) begin
            errs++;
            $display("FAIL ovf_result: got ofm=%0d ovf=%b (ok=%b%b) need 41/1",
                     $signed(ofm_out), ch_ovf, okb, ok);
        end
        if (ok) take_out();
    endtask

    task automatic test_reset_mid();
        logic signed [7:0] v;
        bit ok;
        drive_beat(8'sd4, 8'sd4, 1'b0, 8'sd0, 5'd0, ok);
        #2;
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({out_valid, ofm_out, ch_ovf} !== 10'b0) begin
            errs++;
            $display("FAIL mid_reset_outputs: got valid=%b ofm=%0d ovf=%b need 0/0/0",
                     out_valid, $signed(ofm_out), ch_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_single(8'sd1, 8'sd2, 8'sd3, 5'd0, v, ok);
        vectors++;
        if (!ok || v !== 8'sd21 || ch_ovf !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset_fresh: got %0d ovf=%b (ok=%b) need 21/0", v, ch_ovf, ok);
        end
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_multi_round();
        test_saturation();
        test_bias_sign();
        test_relu();
        test_backpressure();
        test_ch_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
